// File: rtl/dip_scanner.sv
// Periodic serial reader for the DIP-switch shift register; presents the switch word in parallel.
// Optional macro DIP_SCANNER_DEBOUNCE_EN: only write a word that matches the previous raw scan.
module dip_scanner #(
    parameter int WIDTH    = 16,
    parameter int SCAN_GAP = 4
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_Enable,
    input  logic             i_DIPData,
    output logic             o_DIPLatch,
    output logic [WIDTH-1:0] o_Data16,
    output logic             o_Valid,
    output logic             o_Changed,
    output logic             o_Busy
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(SCAN_GAP);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

    state_t           state;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    // Only WIDTH-1 bits are stored: the final sample goes straight into the assembled word.
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] word;

`ifdef DIP_SCANNER_DEBOUNCE_EN
    logic [WIDTH-1:0] raw;
    logic             raw_vld;
`endif

    assign word = {shreg, i_DIPData};

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shreg      <= '0;
            o_DIPLatch <= 1'b0;
            o_Data16   <= '0;
            o_Valid    <= 1'b0;
            o_Changed  <= 1'b0;
            o_Busy     <= 1'b0;
`ifdef DIP_SCANNER_DEBOUNCE_EN
            raw        <= '0;
            raw_vld    <= 1'b0;
`endif
        end else begin
            o_DIPLatch <= 1'b0;
            o_Valid    <= 1'b0;
            o_Changed  <= 1'b0;
            case (state)
                IDLE: begin
                    // Leaving on count 1 makes IDLE last exactly SCAN_GAP cycles after a scan.
                    if (gap_cnt <= GW'(1) && i_Enable) begin
                        state      <= LOAD;
                        gap_cnt    <= '0;
                        o_DIPLatch <= 1'b1;
                        o_Busy     <= 1'b1;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    shreg   <= word[WIDTH-2:0];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        // The write is registered on the last sample so o_Valid is high during UPDATE.
                        state <= UPDATE;
`ifdef DIP_SCANNER_DEBOUNCE_EN
                        if (raw_vld && word == raw) begin
                            o_Data16  <= word;
                            o_Valid   <= 1'b1;
                            o_Changed <= (word != o_Data16);
                        end
                        raw     <= word;
                        raw_vld <= 1'b1;
`else
                        o_Data16  <= word;
                        o_Valid   <= 1'b1;
                        o_Changed <= (word != o_Data16);
`endif
                    end
                end
                UPDATE: begin
                    gap_cnt <= GAP_LOAD;
                    if (SCAN_GAP == 0 && i_Enable) begin
                        state      <= LOAD;
                        o_DIPLatch <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dip_scanner.md
# dip_scanner

Serial reader for the board's DIP-switch shift register. It periodically commits the switch states with `o_DIPLatch`, then shifts them in bit-serially from `i_DIPData` and presents them as a parallel word. It sits in the 5 MHz peripheral clock domain, upstream of `LED_Driver`, whose `i_Data16` input it feeds directly. It also gives the CPU a stable switch-input register.

## Interface
- `WIDTH`, 16: number of switch bits per scan.
- `SCAN_GAP`, 4: idle cycles between the end of one scan and the next latch.
- `i_CLK`  in  1: peripheral clock, the same 5 MHz clock that drives `LED_Driver`. The external register is clocked by `o_PSCLK = ~i_CLK`.
- `i_RESET`  in  1: reset, asynchronous, active-low.
- `i_Enable`  in  1: allows new scans to start.
- `i_DIPData`  in  1: serial switch data from the external register, MSB first.
- `o_DIPLatch`  out  1: high for one cycle to commit the switch states into the external register.
- `o_Data16`  out  WIDTH: last accepted switch word.
- `o_Valid`  out  1: one-cycle pulse when `o_Data16` is written.
- `o_Changed`  out  1: one-cycle pulse, coincident with `o_Valid`, when the written value differs from the previous one.
- `o_Busy`  out  1: high in the LOAD, SHIFT and UPDATE states.

## Operation
- States: IDLE, LOAD, SHIFT, UPDATE.
- IDLE
  - Gap counter counts down.
  - Go to LOAD when counter = 0 and `i_Enable` = 1.
  - Otherwise stay in IDLE; the counter holds at 0.
- LOAD
  - Lasts exactly 1 cycle with `o_DIPLatch` = 1.
  - Bit counter is cleared; next state is SHIFT.
- SHIFT
  - Lasts exactly WIDTH cycles.
  - On each rising edge, `i_DIPData` is shifted into the shift register at bit 0, with older bits moving toward the MSB. The first sampled bit therefore ends at bit WIDTH-1.
  - After the WIDTH-th sample, go to UPDATE.
- UPDATE
  - Lasts 1 cycle and applies the write rule (see Configuration).
  - Loads the gap counter with SCAN_GAP, then goes to IDLE.
- `i_Enable` is checked only in IDLE. Deasserting it mid-scan does not abort the scan; the current scan completes and is written.
- The bit counter is sized `$clog2(WIDTH+1)`. The gap counter is sized `$clog2(SCAN_GAP+1)`. SCAN_GAP = 0 is legal and gives back-to-back scans.
- `o_Changed` compares against the previous `o_Data16`. The first write after reset compares against 0.

## Timing
- Reset values: state IDLE, gap counter 0, shift register 0, `o_DIPLatch` 0, `o_Data16` 0, `o_Valid` 0, `o_Changed` 0, `o_Busy` 0.
- Reset asserted mid-scan clears everything immediately, asynchronously. No partial word is ever written to `o_Data16`.
- First rising edge after reset release with `i_Enable` = 1: IDLE→LOAD.
- All outputs are registered. `o_DIPLatch` is high during the cycle after that edge.
- Scan period with `i_Enable` held high is 1 + WIDTH + 1 + SCAN_GAP cycles; 22 cycles with the defaults.
- Latency from the LOAD cycle start to `o_Valid` = 1 is WIDTH + 1 cycles.
- `o_Data16` changes on the same edge that raises `o_Valid`, and is held stable between writes.
- Sampling is on rising `i_CLK`; the external data changes on rising `o_PSCLK`, which is falling `i_CLK`.

## Configuration
- Macro: `DIP_SCANNER_DEBOUNCE_EN`.
- Defined:
  - UPDATE writes `o_Data16` only if the shift register equals the previous scan's raw word, held in an extra WIDTH-bit register.
  - The raw-word register updates every scan.
  - `o_Valid` and `o_Changed` pulse only on an actual write.
  - The first write after reset needs two consecutive identical scans.
- Undefined: every UPDATE writes `o_Data16` and pulses `o_Valid`. The raw-word register is not built.

## Test plan
- **Reset then scan, serial stream `16'hA5C3` MSB first, defaults, debounce off:** `o_DIPLatch` high 1 cycle, then `o_Valid` 17 cycles after the LOAD cycle. `o_Data16` = `16'hA5C3` and `o_Changed` = 1.
- **Same `16'hA5C3` scanned again:** `o_Valid` pulses 22 cycles after the previous one, with `o_Changed` = 0.
- **`i_Enable` dropped during SHIFT bit 5:** the scan completes and writes. The next LOAD does not occur until `i_Enable` returns high, and follows it by 1 edge.
- **Reset asserted at SHIFT bit 8 with stream `16'hFFFF`:** `o_Data16` = 0 and `o_DIPLatch` = 0 immediately. No `o_Valid` is produced.
- **Debounce on, scans `16'h1234`, `16'h1235`, `16'h1235`:** no write after scan 1 or scan 2. After scan 3, `o_Data16` = `16'h1235` with `o_Valid` = `o_Changed` = 1.
- **SCAN_GAP = 0:** LOAD immediately follows UPDATE, giving a scan period of 18 cycles.
